arm_core_single_cycle: RTL and testbench

- Single-cycle 32-bit ARMv3-subset processor core: one instruction fetched, executed and retired per CLK rising edge.
- Sits under the board wrapper. It fetches from an external combinational instruction ROM addressed by PC.
- It reads and writes an external data memory through ALUResult, WriteData, ReadData and MemWrite.
- The wrapper decodes ALUResult into constant (0x200–0x3FC) and variable (0x800–0x9FC) regions.

---
 rtl/arm_core_single_cycle_if.sv | 19 +
 rtl/arm_core_single_cycle.sv | 184 ++++++++++++++++++
 tb/tb_arm_core_single_cycle.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/arm_core_single_cycle_if.sv
// rtl/arm_core_single_cycle_if.sv - instruction/data memory bus between core and board wrapper
interface arm_core_single_cycle_if;
  logic [31:0] Instr;
  logic [31:0] ReadData;
  logic        MemWrite;
  logic [31:0] PC;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;

  modport master (
    input  Instr, ReadData,
    output MemWrite, PC, ALUResult, WriteData
  );

  modport slave (
    output Instr, ReadData,
    input  MemWrite, PC, ALUResult, WriteData
  );
endinterface

// File: rtl/arm_core_single_cycle.sv
// rtl/arm_core_single_cycle.sv - single-cycle ARMv3-subset core: data processing, LDR/STR imm, B/BL
module arm_core_single_cycle #(
  parameter logic [31:0] PC_RESET = 32'h00000000
) (
  input  logic                           CLK,
  input  logic                           RESET,
  arm_core_single_cycle_if.master        bus
);

  logic [31:0] r_pc;
  logic [31:0] r_regs [0:14];
  logic        r_n, r_z, r_c, r_v;

  logic [31:0] w_instr, w_pc4, w_pc8;
  logic [3:0]  w_cond, w_opcode, w_rn, w_rd, w_rm;
  logic [4:0]  w_shamt;
  logic [31:0] w_rn_val, w_rd_val, w_rm_val;
  logic        w_cond_pass;

  assign w_instr  = bus.Instr;
  assign w_cond   = w_instr[31:28];
  assign w_opcode = w_instr[24:21];
  assign w_rn     = w_instr[19:16];
  assign w_rd     = w_instr[15:12];
  assign w_rm     = w_instr[3:0];
  assign w_shamt  = w_instr[11:7];
  assign w_pc4    = r_pc + 32'd4;
  assign w_pc8    = r_pc + 32'd8;

  // R15 as an operand reads as PC+8
  assign w_rn_val = (w_rn == 4'd15) ? w_pc8 : r_regs[w_rn];
  assign w_rd_val = (w_rd == 4'd15) ? w_pc8 : r_regs[w_rd];
  assign w_rm_val = (w_rm == 4'd15) ? w_pc8 : r_regs[w_rm];

  always_comb begin
    w_cond_pass = 1'b0;
    case (w_cond)
      4'h0: w_cond_pass = r_z;
      4'h1: w_cond_pass = !r_z;
      4'h2: w_cond_pass = r_c;
      4'h3: w_cond_pass = !r_c;
      4'h4: w_cond_pass = r_n;
      4'h5: w_cond_pass = !r_n;
      4'h6: w_cond_pass = r_v;
      4'h7: w_cond_pass = !r_v;
      4'h8: w_cond_pass = r_c && !r_z;
      4'h9: w_cond_pass = !r_c || r_z;
      4'hA: w_cond_pass = (r_n == r_v);
      4'hB: w_cond_pass = (r_n != r_v);
      4'hC: w_cond_pass = !r_z && (r_n == r_v);
      4'hD: w_cond_pass = r_z || (r_n != r_v);
      4'hE: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  logic [31:0] w_op2, w_imm32, w_imm_rot, w_ror_v;
  logic        w_sh_c;
  logic [4:0]  w_rot2;
  logic [32:0] w_lsl_t, w_lsr_t, w_asr_t;

  assign w_imm32   = {24'd0, w_instr[7:0]};
  assign w_rot2    = {w_instr[11:8], 1'b0};
  assign w_imm_rot = (w_imm32 >> w_rot2) | (w_imm32 << (6'd32 - {1'b0, w_rot2}));

  always_comb begin
    w_lsl_t = {1'b0, w_rm_val} << w_shamt;
    w_lsr_t = {w_rm_val, 1'b0} >> w_shamt;
    w_asr_t = $signed({w_rm_val, 1'b0}) >>> w_shamt;
    w_ror_v = (w_rm_val >> w_shamt) | (w_rm_val << (6'd32 - {1'b0, w_shamt}));
    w_op2   = w_rm_val;
    w_sh_c  = r_c;
    if (w_instr[25]) begin
      w_op2  = w_imm_rot;
      w_sh_c = (w_rot2 == 5'd0) ? r_c : w_imm_rot[31];
    end else if (w_shamt != 5'd0) begin
      case (w_instr[6:5])
        2'b00:   begin w_op2 = w_lsl_t[31:0]; w_sh_c = w_lsl_t[32]; end
        2'b01:   begin w_op2 = w_lsr_t[32:1]; w_sh_c = w_lsr_t[0];  end
        2'b10:   begin w_op2 = w_asr_t[32:1]; w_sh_c = w_asr_t[0];  end
        default: begin w_op2 = w_ror_v;       w_sh_c = w_ror_v[31]; end
      endcase
    end
  end

  // Subtracts are folded into one adder by inverting an input; SBC/RSC take C as carry-in
  logic [31:0] w_add_x, w_add_y, w_result;
  logic        w_add_cin;
  logic [32:0] w_sum;
  logic        w_arith, w_test, w_ovf;

  always_comb begin
    w_add_x   = w_rn_val;
    w_add_y   = w_op2;
    w_add_cin = 1'b0;
    case (w_opcode)
      4'h2, 4'hA: begin w_add_y = ~w_op2; w_add_cin = 1'b1; end
      4'h3:       begin w_add_x = w_op2; w_add_y = ~w_rn_val; w_add_cin = 1'b1; end
      4'h5:       w_add_cin = r_c;
      4'h6:       begin w_add_y = ~w_op2; w_add_cin = r_c; end
      4'h7:       begin w_add_x = w_op2; w_add_y = ~w_rn_val; w_add_cin = r_c; end
      default:    w_add_cin = 1'b0;
    endcase
    w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {32'd0, w_add_cin};
    case (w_opcode)
      4'h0, 4'h8: w_result = w_rn_val & w_op2;
      4'h1, 4'h9: w_result = w_rn_val ^ w_op2;
      4'hC:       w_result = w_rn_val | w_op2;
      4'hD:       w_result = w_op2;
      4'hE:       w_result = w_rn_val & ~w_op2;
      4'hF:       w_result = ~w_op2;
      default:    w_result = w_sum[31:0];
    endcase
  end

  assign w_arith = (w_opcode[3:2] == 2'b01) || (w_opcode[3:1] == 3'b001) || (w_opcode[3:1] == 3'b101);
  assign w_test  = (w_opcode[3:2] == 2'b10);
  assign w_ovf   = (w_add_x[31] == w_add_y[31]) && (w_sum[31] != w_add_x[31]);

  logic        w_is_dp, w_is_mem, w_is_br;
  logic [31:0] w_mem_addr, w_br_target;

  assign w_is_dp     = (w_instr[27:26] == 2'b00) && (w_instr[25] || !w_instr[4]);
  assign w_is_mem    = (w_instr[27:26] == 2'b01) && !w_instr[25] && w_instr[24] && !w_instr[22] && !w_instr[21];
  assign w_is_br     = (w_instr[27:25] == 3'b101);
  assign w_mem_addr  = w_instr[23] ? (w_rn_val + {20'd0, w_instr[11:0]}) : (w_rn_val - {20'd0, w_instr[11:0]});
  assign w_br_target = w_pc8 + {{6{w_instr[23]}}, w_instr[23:0], 2'b00};

  logic        w_rf_we, w_flags_we;
  logic [3:0]  w_rf_wa;
  logic [31:0] w_rf_wd, w_pc_next;

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wa    = w_rd;
    w_rf_wd    = w_result;
    w_flags_we = 1'b0;
    w_pc_next  = w_pc4;
    if (w_cond_pass) begin
      if (w_is_dp) begin
        w_flags_we = w_instr[20] || w_test;
        if (!w_test) begin
          if (w_rd == 4'd15) w_pc_next = w_result;
          else               w_rf_we   = 1'b1;
        end
      end else if (w_is_mem && w_instr[20]) begin
        w_rf_wd = bus.ReadData;
        if (w_rd == 4'd15) w_pc_next = bus.ReadData;
        else               w_rf_we   = 1'b1;
      end else if (w_is_br) begin
        w_pc_next = w_br_target;
        w_rf_we   = w_instr[24];
        w_rf_wa   = 4'd14;
        w_rf_wd   = w_pc4;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc <= PC_RESET;
      for (int i = 0; i < 15; i++) r_regs[i] <= 32'd0;
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_rf_we) r_regs[w_rf_wa] <= w_rf_wd;
      if (w_flags_we) begin
        r_n <= w_result[31];
        r_z <= (w_result == 32'd0);
        r_c <= w_arith ? w_sum[32] : w_sh_c;
        r_v <= w_arith ? w_ovf : r_v;
      end
    end
  end

  assign bus.PC        = r_pc;
  assign bus.ALUResult = w_is_mem ? w_mem_addr : (w_is_br ? w_br_target : w_result);
  assign bus.WriteData = w_rd_val;
  assign bus.MemWrite  = RESET && w_cond_pass && w_is_mem && !w_instr[20];

endmodule

// File: tb/tb_arm_core_single_cycle.sv
// tb/tb_arm_core_single_cycle.sv - directed-vector bench for arm_core_single_cycle
module tb_arm_core_single_cycle;
  logic CLK;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  arm_core_single_cycle_if bus ();

  arm_core_single_cycle #(.PC_RESET(32'h00000000)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] rdat);
    bus.Instr    = ins;
    bus.ReadData = rdat;
    #1;
  endtask

  task automatic run(input logic [31:0] ins);
    drive(ins, 32'd0);
    tick();
  endtask

  task automatic peek(input logic [3:0] rd);
    drive(32'hF0000000 | ({28'd0, rd} << 12), 32'd0);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    drive(32'hF0000000, 32'd0);
    tick();
    RESET = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    drive(32'hE5801004, 32'd0);
    checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite got %b exp 0", bus.MemWrite); end
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 00000000", bus.PC); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.PC !== 32'h0 || bus.MemWrite !== 1'b0) begin errors++; $display("FAIL rst_hold pc %h mw %b exp 00000000 0", bus.PC, bus.MemWrite); end
    end
    RESET = 1'b1;
    drive(32'hF0000000, 32'd0);
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL rst_release got %h exp 00000000", bus.PC); end
    tick();
    checks++; if (bus.PC !== 32'h4) begin errors++; $display("FAIL rst_step1 got %h exp 00000004", bus.PC); end
    tick();
    checks++; if (bus.PC !== 32'h8) begin errors++; $display("FAIL rst_step2 got %h exp 00000008", bus.PC); end
    RESET = 1'b0;
    #1;
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL rst_async got %h exp 00000000", bus.PC); end
    RESET = 1'b1;
    #1;
  endtask

  task automatic test_load();
    do_reset();
    drive(32'hE59F1204, 32'd5);
    checks++; if (bus.ALUResult !== 32'h20C) begin errors++; $display("FAIL ldr_addr got %h exp 0000020c", bus.ALUResult); end
    checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL ldr_memwrite got %b exp 0", bus.MemWrite); end
    tick();
    checks++; if (bus.PC !== 32'h4) begin errors++; $display("FAIL ldr_pc got %h exp 00000004", bus.PC); end
    peek(4'd1);
    checks++; if (bus.WriteData !== 32'd5) begin errors++; $display("FAIL ldr_r1 got %h exp 00000005", bus.WriteData); end
  endtask

  task automatic test_flags_branch();
    do_reset();
    run(32'hE3A01006);
    run(32'hE3A02006);
    drive(32'hE1510002, 32'd0);
    checks++; if (bus.ALUResult !== 32'h0) begin errors++; $display("FAIL cmp_eq_res got %h exp 00000000", bus.ALUResult); end
    tick();
    drive(32'h1A000002, 32'd0);
    checks++; if (bus.ALUResult !== 32'h1C) begin errors++; $display("FAIL bne_target got %h exp 0000001c", bus.ALUResult); end
    tick();
    checks++; if (bus.PC !== 32'h10) begin errors++; $display("FAIL bne_not_taken got %h exp 00000010", bus.PC); end
    run(32'h0A000002);
    checks++; if (bus.PC !== 32'h20) begin errors++; $display("FAIL beq_taken got %h exp 00000020", bus.PC); end
    run(32'h2A000000);
    checks++; if (bus.PC !== 32'h28) begin errors++; $display("FAIL bcs_taken got %h exp 00000028", bus.PC); end
    peek(4'd0);
    checks++; if (bus.WriteData !== 32'h0) begin errors++; $display("FAIL cmp_no_write got %h exp 00000000", bus.WriteData); end

    do_reset();
    run(32'hE3A01006);
    run(32'hE3A02007);
    drive(32'hE1510002, 32'd0);
    checks++; if (bus.ALUResult !== 32'hFFFFFFFF) begin errors++; $display("FAIL cmp_lt_res got %h exp ffffffff", bus.ALUResult); end
    tick();
    run(32'h0A000002);
    checks++; if (bus.PC !== 32'h10) begin errors++; $display("FAIL beq_not_taken got %h exp 00000010", bus.PC); end
    run(32'h3A000000);
    checks++; if (bus.PC !== 32'h18) begin errors++; $display("FAIL bcc_taken got %h exp 00000018", bus.PC); end
    run(32'hBA000000);
    checks++; if (bus.PC !== 32'h20) begin errors++; $display("FAIL blt_taken got %h exp 00000020", bus.PC); end
  endtask

  task automatic test_carry();
    do_reset();
    drive(32'hE3E05000, 32'd0);
    checks++; if (bus.ALUResult !== 32'hFFFFFFFF) begin errors++; $display("FAIL mvn_res got %h exp ffffffff", bus.ALUResult); end
    tick();
    run(32'hE3A07001);
    drive(32'hE0975005, 32'd0);
    checks++; if (bus.ALUResult !== 32'h0) begin errors++; $display("FAIL adds_res got %h exp 00000000", bus.ALUResult); end
    tick();
    peek(4'd5);
    checks++; if (bus.WriteData !== 32'h0) begin errors++; $display("FAIL adds_r5 got %h exp 00000000", bus.WriteData); end
    drive(32'hE2A66000, 32'd0);
    checks++; if (bus.ALUResult !== 32'h1) begin errors++; $display("FAIL adc_res got %h exp 00000001", bus.ALUResult); end
    tick();
    peek(4'd6);
    checks++; if (bus.WriteData !== 32'h1) begin errors++; $display("FAIL adc_r6 got %h exp 00000001", bus.WriteData); end
    run(32'h0A000002);
    checks++; if (bus.PC !== 32'h20) begin errors++; $display("FAIL adds_z_branch got %h exp 00000020", bus.PC); end
    run(32'h2A000000);
    checks++; if (bus.PC !== 32'h28) begin errors++; $display("FAIL adds_c_branch got %h exp 00000028", bus.PC); end
    drive(32'hE0E75005, 32'd0);
    checks++; if (bus.ALUResult !== 32'hFFFFFFFF) begin errors++; $display("FAIL rsc_c1 got %h exp ffffffff", bus.ALUResult); end
    tick();
    peek(4'd5);
    checks++; if (bus.WriteData !== 32'hFFFFFFFF) begin errors++; $display("FAIL rsc_r5 got %h exp ffffffff", bus.WriteData); end
    drive(32'hE1B09087, 32'd0);
    checks++; if (bus.ALUResult !== 32'h2) begin errors++; $display("FAIL movs_lsl got %h exp 00000002", bus.ALUResult); end
    tick();
    drive(32'hE0E7A005, 32'd0);
    checks++; if (bus.ALUResult !== 32'hFFFFFFFD) begin errors++; $display("FAIL rsc_c0 got %h exp fffffffd", bus.ALUResult); end
    tick();
    drive(32'hE3A0C4FF, 32'd0);
    checks++; if (bus.ALUResult !== 32'hFF000000) begin errors++; $display("FAIL imm_rot got %h exp ff000000", bus.ALUResult); end
    tick();
    drive(32'hE1B090A7, 32'd0);
    checks++; if (bus.ALUResult !== 32'h0) begin errors++; $display("FAIL movs_lsr got %h exp 00000000", bus.ALUResult); end
    tick();
    run(32'h0A000002);
    checks++; if (bus.PC !== 32'h4C) begin errors++; $display("FAIL lsr_z_branch got %h exp 0000004c", bus.PC); end
    run(32'h2A000000);
    checks++; if (bus.PC !== 32'h54) begin errors++; $display("FAIL lsr_c_branch got %h exp 00000054", bus.PC); end
    drive(32'hE1A0B0CA, 32'd0);
    checks++; if (bus.ALUResult !== 32'hFFFFFFFE) begin errors++; $display("FAIL asr_res got %h exp fffffffe", bus.ALUResult); end
    drive(32'hE1A0B0E7, 32'd0);
    checks++; if (bus.ALUResult !== 32'h80000000) begin errors++; $display("FAIL ror_res got %h exp 80000000", bus.ALUResult); end
  endtask

  task automatic test_store();
    do_reset();
    drive(32'hE3A00B02, 32'd0);
    checks++; if (bus.ALUResult !== 32'h800) begin errors++; $display("FAIL mov_800 got %h exp 00000800", bus.ALUResult); end
    tick();
    run(32'hE3A010AB);
    drive(32'hE5801004, 32'd0);
    checks++; if (bus.MemWrite !== 1'b1) begin errors++; $display("FAIL str_memwrite got %b exp 1", bus.MemWrite); end
    checks++; if (bus.ALUResult !== 32'h804) begin errors++; $display("FAIL str_addr got %h exp 00000804", bus.ALUResult); end
    checks++; if (bus.WriteData !== 32'hAB) begin errors++; $display("FAIL str_data got %h exp 000000ab", bus.WriteData); end
    tick();
    run(32'hE1500001);
    drive(32'h05001004, 32'd0);
    checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL streq_memwrite got %b exp 0", bus.MemWrite); end
    checks++; if (bus.ALUResult !== 32'h7FC) begin errors++; $display("FAIL streq_addr got %h exp 000007fc", bus.ALUResult); end
    tick();
    checks++; if (bus.PC !== 32'h14) begin errors++; $display("FAIL streq_pc got %h exp 00000014", bus.PC); end
    drive(32'hF5801004, 32'd0);
    checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL strnv_memwrite got %b exp 0", bus.MemWrite); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(32'hEA000023, 32'd0);
    checks++; if (bus.ALUResult !== 32'h94) begin errors++; $display("FAIL b_target got %h exp 00000094", bus.ALUResult); end
    tick();
    checks++; if (bus.PC !== 32'h94) begin errors++; $display("FAIL b_fwd got %h exp 00000094", bus.PC); end
    drive(32'hEAFFFFFE, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.PC !== 32'h94) begin errors++; $display("FAIL b_self got %h exp 00000094", bus.PC); end
    end
    do_reset();
    for (int i = 0; i < 4; i++) run(32'hF0000000);
    checks++; if (bus.PC !== 32'h10) begin errors++; $display("FAIL nv_step got %h exp 00000010", bus.PC); end
    run(32'hEB000001);
    checks++; if (bus.PC !== 32'h1C) begin errors++; $display("FAIL bl_pc got %h exp 0000001c", bus.PC); end
    peek(4'd14);
    checks++; if (bus.WriteData !== 32'h14) begin errors++; $display("FAIL bl_lr got %h exp 00000014", bus.WriteData); end
    drive(32'hE590F000, 32'h40);
    tick();
    checks++; if (bus.PC !== 32'h40) begin errors++; $display("FAIL ldr_pc_load got %h exp 00000040", bus.PC); end
    run(32'hE3A02005);
    run(32'hE1A01112);
    checks++; if (bus.PC !== 32'h48) begin errors++; $display("FAIL regshift_pc got %h exp 00000048", bus.PC); end
    peek(4'd1);
    checks++; if (bus.WriteData !== 32'h0) begin errors++; $display("FAIL regshift_nop got %h exp 00000000", bus.WriteData); end
  endtask

  initial begin
    RESET        = 1'b0;
    bus.Instr    = 32'hF0000000;
    bus.ReadData = 32'd0;
    #2;
    test_reset();
    test_load();
    test_flags_branch();
    test_carry();
    test_store();
    test_branch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
